// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: FSM encodings, fetch constants, address helper.
package fetch_unit_pkg;

  // IDLE: no request outstanding. WAIT: request accepted, response not yet seen.
  typedef enum logic [0:0] {
    FETCH_IDLE = 1'b0,
    FETCH_WAIT = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] PC_STEP = 32'd4;

  // Instruction addresses are word aligned; low two bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bus: instruction-memory request/response, redirect and decode handshake.
//
// Handshake rules: a request transfers on a clock edge where imem_req_valid and
// imem_req_ready are both 1; while valid is held without ready the address stays
// stable. Responses have no ready: imem_rsp_valid delivers one word, in order, for
// the single outstanding request. Decode consumes the head on an edge where
// instr_valid and instr_ready are both 1. redirect is a one-cycle command.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  // Fetch unit side.
  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, instr_ready
  );

  // Memory / decode / branch-resolution side.
  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_unit_fifo.sv
// Prefetch queue: DEPTH x 64b circular buffer holding {pc, instr}, with a count
// register. Flush wins over push and pop; pop on empty and push on full are ignored.
module fetch_unit_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [63:0]                din_i,
  output logic [63:0]                dout_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   count_q, count_d;
  logic          pop_ok, push_ok;

  assign empty_o = (count_q == '0);
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & ((count_q < (AW+1)'(DEPTH)) | pop_ok);
  assign dout_o  = mem_q[rd_q];
  assign count_o = count_q;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush_i) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (push_ok) wr_d = wr_q + AW'(1);
      if (pop_ok)  rd_d = rd_q + AW'(1);
      if (push_ok && !pop_ok) count_d = count_q + (AW+1)'(1);
      if (pop_ok && !push_ok) count_d = count_q - (AW+1)'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are only observed through a valid head.
  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps at most one imem read outstanding,
// buffers returned words with their PCs, and flushes/restarts on redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus,
  output fetch_state_e dbg_state_o
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          discard_q, discard_d;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic [63:0]   fifo_dout;
  logic [CW:0]   occupancy;
  logic          in_wait, rsp_in_wait, room, req_valid, req_fire, push, pop;

  // Room counts the in-flight word so a response always has a slot; the
  // registered count is used, so a pop in the same cycle does not create room.
  assign in_wait     = (state_q == FETCH_WAIT);
  assign rsp_in_wait = in_wait & bus.imem_rsp_valid;
  assign occupancy   = {1'b0, fifo_count} + {{CW{1'b0}}, in_wait};
  assign room        = occupancy < (CW+1)'(DEPTH);
  assign req_valid   = reset & ~bus.redirect & room & (~in_wait | bus.imem_rsp_valid);
  assign req_fire    = req_valid & bus.imem_req_ready;
  assign push        = rsp_in_wait & ~discard_q & ~bus.redirect;
  assign pop         = ~fifo_empty & bus.instr_ready & ~bus.redirect;

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.instr_valid    = ~fifo_empty;
  assign bus.instr          = fifo_empty ? 32'h0 : fifo_dout[31:0];
  assign bus.instr_pc       = fifo_empty ? 32'h0 : fifo_dout[63:32];
  assign dbg_state_o        = state_q;

  // Next PC, FSM and discard flag; redirect overrides any normal progress.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    discard_d  = discard_q;
    if (bus.redirect) begin
      fetch_pc_d = word_align(bus.redirect_pc);
      if (in_wait) begin
        if (bus.imem_rsp_valid) begin
          state_d   = FETCH_IDLE;
          discard_d = 1'b0;
        end else begin
          discard_d = 1'b1;
        end
      end
    end else begin
      if (rsp_in_wait) begin
        state_d   = FETCH_IDLE;
        discard_d = 1'b0;
      end
      if (req_fire) begin
        state_d    = FETCH_WAIT;
        fetch_pc_d = fetch_pc_q + PC_STEP;
        req_pc_d   = fetch_pc_q;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= FETCH_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      discard_q  <= discard_d;
    end
  end

  fetch_unit_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (bus.redirect),
    .din_i   ({req_pc_q, bus.imem_rsp_data}),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  // A response with nothing outstanding is a memory protocol error.
  rsp_only_in_wait_a: assert property (@(posedge clk) disable iff (!reset)
    !(bus.imem_rsp_valid && !in_wait));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-programmable imem model, a pop
// scoreboard of expected PCs, and directed steps for streaming, stall,
// redirect and reset cases. Memory word at address a is ~a.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic         clk;
  logic         reset;
  fetch_state_e dbg_state;
  fetch_unit_if bus ();

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  // imem model state
  int          mem_lat;
  logic        pend_valid;
  logic [31:0] pend_addr;
  int          pend_cnt;
  int          acc_count;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // Clock: 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: sample the handshakes before the edge, then update the imem model.
  task automatic tick();
    logic        acc;
    logic [31:0] acc_addr;
    logic        rsp_taken;
    logic [31:0] pc_e;
    @(negedge clk);
    acc       = reset & bus.imem_req_valid & bus.imem_req_ready;
    acc_addr  = bus.imem_req_addr;
    rsp_taken = bus.imem_rsp_valid;
    if (reset && bus.instr_valid && bus.instr_ready && !bus.redirect) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL pop_unexpected observed=%h expected=none", bus.instr_pc);
      end
      if (exp_q.size() > 0) begin
        pc_e = exp_q.pop_front();
        chk("pop_pc", bus.instr_pc, pc_e);
        chk("pop_instr", bus.instr, ~pc_e);
      end
    end
    @(posedge clk);
    #1;
    if (rsp_taken) begin
      pend_valid         = 1'b0;
      bus.imem_rsp_valid = 1'b0;
    end
    if (acc) begin
      pend_valid = 1'b1;
      pend_addr  = acc_addr;
      pend_cnt   = mem_lat;
      acc_count++;
    end
    if (pend_valid && !bus.imem_rsp_valid) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = ~pend_addr;
      end
    end
    #1;
  endtask

  // Reset DUT and imem together; returns 2 units after a rising edge with reset released.
  task automatic do_reset();
    reset              = 1'b0;
    bus.redirect       = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    pend_valid         = 1'b0;
    acc_count          = 0;
    exp_q.delete();
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
  endtask

  initial begin
    reset              = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.redirect       = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.instr_ready    = 1'b1;
    mem_lat            = 1;
    pend_valid         = 1'b0;
    pend_addr          = 32'h0;
    pend_cnt           = 0;
    acc_count          = 0;

    // Reset values
    @(posedge clk);
    #1;
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
    chk("rst_instr_valid", 32'(bus.instr_valid), 32'h0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_instr_pc", bus.instr_pc, 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(FETCH_IDLE));

    // Streaming with 1-cycle memory
    do_reset();
    for (int i = 0; i < 16; i++) exp_q.push_back(32'(i * 4));
    chk("a_req_valid0", 32'(bus.imem_req_valid), 32'h1);
    chk("a_req_addr0", bus.imem_req_addr, 32'h0);
    tick();
    chk("a_req_addr1", bus.imem_req_addr, 32'h4);
    chk("a_req_valid1", 32'(bus.imem_req_valid), 32'h1);
    chk("a_instr_valid1", 32'(bus.instr_valid), 32'h0);
    tick();
    chk("a_instr_valid2", 32'(bus.instr_valid), 32'h1);
    chk("a_instr_pc2", bus.instr_pc, 32'h0);
    chk("a_req_addr2", bus.imem_req_addr, 32'h8);
    tick();
    chk("a_acc_count", 32'(acc_count), 32'd3);
    chk("a_instr_pc3", bus.instr_pc, 32'h4);
    tick();
    chk("a_instr_pc4", bus.instr_pc, 32'h8);
    tick();
    chk("a_instr_pc5", bus.instr_pc, 32'hC);

    // Decode stalled: queue fills to DEPTH, then resumes in order
    do_reset();
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 16; i++) exp_q.push_back(32'(i * 4));
    repeat (5) tick();
    chk("b_acc_count", 32'(acc_count), 32'd4);
    chk("b_req_valid_full", 32'(bus.imem_req_valid), 32'h0);
    chk("b_head_pc", bus.instr_pc, 32'h0);
    chk("b_state_idle", 32'(dbg_state), 32'(FETCH_IDLE));
    tick();
    chk("b_acc_count_hold", 32'(acc_count), 32'd4);
    bus.instr_ready = 1'b1;
    #1;
    chk("b_req_valid_samecycle", 32'(bus.imem_req_valid), 32'h0);
    tick();
    chk("b_resume_valid", 32'(bus.imem_req_valid), 32'h1);
    chk("b_resume_addr", bus.imem_req_addr, 32'h10);
    chk("b_head_pc1", bus.instr_pc, 32'h4);
    tick();
    chk("b_head_pc2", bus.instr_pc, 32'h8);
    tick();
    tick();
    chk("b_head_pc4", bus.instr_pc, 32'h10);

    // 3-cycle memory, redirect to 0x103 while waiting
    do_reset();
    mem_lat = 3;
    tick();
    chk("c_state_wait", 32'(dbg_state), 32'(FETCH_WAIT));
    chk("c_req_valid_wait", 32'(bus.imem_req_valid), 32'h0);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h100 + 32'(i * 4));
    tick();
    bus.redirect = 1'b0;
    #1;
    chk("c_state_wait2", 32'(dbg_state), 32'(FETCH_WAIT));
    chk("c_req_valid_stale", 32'(bus.imem_req_valid), 32'h0);
    tick();
    chk("c_new_req_valid", 32'(bus.imem_req_valid), 32'h1);
    chk("c_new_req_addr", bus.imem_req_addr, 32'h100);
    tick();
    chk("c_drop_instr_valid", 32'(bus.instr_valid), 32'h0);
    tick();
    tick();
    chk("c_instr_valid_pre", 32'(bus.instr_valid), 32'h0);
    tick();
    chk("c_instr_valid", 32'(bus.instr_valid), 32'h1);
    chk("c_instr_pc", bus.instr_pc, 32'h100);
    chk("c_instr", bus.instr, ~32'h100);

    // Redirect coinciding with a response and a pop
    do_reset();
    mem_lat = 1;
    exp_q.push_back(32'h0);
    tick();
    tick();
    chk("d_instr_valid", 32'(bus.instr_valid), 32'h1);
    chk("d_rsp_present", 32'(bus.imem_rsp_valid), 32'h1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0200;
    #1;
    chk("d_req_valid_redirect", 32'(bus.imem_req_valid), 32'h0);
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h200 + 32'(i * 4));
    tick();
    bus.redirect = 1'b0;
    #1;
    chk("d_flushed", 32'(bus.instr_valid), 32'h0);
    chk("d_state_idle", 32'(dbg_state), 32'(FETCH_IDLE));
    chk("d_req_addr", bus.imem_req_addr, 32'h200);
    tick();
    tick();
    chk("d_instr_pc", bus.instr_pc, 32'h200);

    // Redirect to the last word: address wraps to 0
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFF;
    exp_q.delete();
    exp_q.push_back(32'hFFFF_FFFC);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
    tick();
    bus.redirect = 1'b0;
    #1;
    chk("e_req_addr0", bus.imem_req_addr, 32'hFFFF_FFFC);
    chk("e_req_valid0", 32'(bus.imem_req_valid), 32'h1);
    tick();
    chk("e_req_addr1", bus.imem_req_addr, 32'h0);
    tick();
    chk("e_instr_pc0", bus.instr_pc, 32'hFFFF_FFFC);
    tick();
    chk("e_instr_pc1", bus.instr_pc, 32'h0);

    // Asynchronous reset in WAIT with two words queued
    do_reset();
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
    repeat (3) tick();
    chk("f_state_wait", 32'(dbg_state), 32'(FETCH_WAIT));
    chk("f_head_pc", bus.instr_pc, 32'h0);
    reset              = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    pend_valid         = 1'b0;
    exp_q.delete();
    #1;
    chk("f_req_valid", 32'(bus.imem_req_valid), 32'h0);
    chk("f_req_addr", bus.imem_req_addr, 32'h0);
    chk("f_instr_valid", 32'(bus.instr_valid), 32'h0);
    chk("f_instr", bus.instr, 32'h0);
    chk("f_instr_pc", bus.instr_pc, 32'h0);
    chk("f_state", 32'(dbg_state), 32'(FETCH_IDLE));
    @(posedge clk);
    #2;
    reset     = 1'b1;
    acc_count = 0;
    #1;
    chk("f_restart_valid", 32'(bus.imem_req_valid), 32'h1);
    chk("f_restart_addr", bus.imem_req_addr, 32'h0);
    tick();
    chk("f_restart_acc", 32'(acc_count), 32'd1);
    chk("f_next_addr", bus.imem_req_addr, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
